// File: rtl/spi_cmd_bridge_pkg.sv
`default_nettype none
// ============================================================================
// spi_cmd_bridge_pkg : command bit positions and FSM encoding for the bridge
// Revision: 1.0
// ============================================================================
package spi_cmd_bridge_pkg;

  localparam int CMD_WR_BIT  = 7;
  localparam int CMD_INC_BIT = 6;
  localparam int CNT_W       = 2;

  typedef enum logic [1:0] {
    S_CMD   = 2'd0,
    S_ADDR  = 2'd1,
    S_WDATA = 2'd2,
    S_RDATA = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_byte_evt.sv
`default_nettype none
// ============================================================================
// spi_byte_evt : turns the data_valid_read toggle into a one-clock byte event
// Revision: 1.0
// ============================================================================
module spi_byte_evt (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] mdata,
  input  logic       data_valid_read,
  input  logic       data_firstbyte,
  output logic       byte_evt,
  output logic [7:0] evt_data,
  output logic       evt_first
);

  logic r_dvr;
  logic w_toggle;

  assign w_toggle = r_dvr ^ data_valid_read;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dvr     <= 1'b0;
      byte_evt  <= 1'b0;
      evt_data  <= 8'h00;
      evt_first <= 1'b0;
    end else begin
      r_dvr    <= data_valid_read;
      byte_evt <= w_toggle;
      if (w_toggle) begin
        evt_data  <= mdata;
        evt_first <= data_firstbyte;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_cmd_bridge.sv
`default_nettype none
// ============================================================================
// spi_cmd_bridge : decodes SPI CMD/ADDR/DATA bytes into register-bus accesses
// Revision: 1.0
// ============================================================================
module spi_cmd_bridge
  import spi_cmd_bridge_pkg::*;
#(
  parameter int ADDR_BYTES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              mdata,
  input  logic                    data_valid_read,
  input  logic                    data_firstbyte,
  output logic [7:0]              sdata,
  output logic [8*ADDR_BYTES-1:0] bus_addr,
  output logic [7:0]              bus_wdata,
  output logic                    bus_we,
  output logic                    bus_re,
  input  logic [7:0]              bus_rdata,
  input  logic                    bus_ack,
  output logic                    overrun
);

  localparam int AW = 8 * ADDR_BYTES;

  logic             w_evt;
  logic [7:0]       w_data;
  logic             w_first;
  logic             w_pending;
  logic             w_last;
  logic [AW-1:0]    w_addr_inc;
  logic [AW-1:0]    w_addr_shift;

  state_t           r_state;
  logic             r_wr;
  logic             r_inc;
  logic [CNT_W-1:0] r_cnt;

  spi_byte_evt u_byte_evt (
    .clk             (clk),
    .rst             (rst),
    .mdata           (mdata),
    .data_valid_read (data_valid_read),
    .data_firstbyte  (data_firstbyte),
    .byte_evt        (w_evt),
    .evt_data        (w_data),
    .evt_first       (w_first)
  );

  // A request acked in this very cycle no longer blocks the incoming byte.
  assign w_pending    = (bus_we | bus_re) & ~bus_ack;
  assign w_last       = (r_cnt == CNT_W'(ADDR_BYTES - 1));
  assign w_addr_inc   = bus_addr + AW'(1);
  assign w_addr_shift = AW'({bus_addr, w_data});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_CMD;
      r_wr      <= 1'b0;
      r_inc     <= 1'b0;
      r_cnt     <= '0;
      sdata     <= 8'h00;
      bus_addr  <= '0;
      bus_wdata <= 8'h00;
      bus_we    <= 1'b0;
      bus_re    <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (bus_ack && bus_we) begin
        bus_we <= 1'b0;
        // An aborted write still completes but must not disturb the new address.
        if (r_state == S_WDATA && r_inc)
          bus_addr <= w_addr_inc;
      end
      if (bus_ack && bus_re) begin
        bus_re <= 1'b0;
        sdata  <= bus_rdata;
      end

      if (w_evt) begin
        if (w_first) begin
          r_wr    <= w_data[CMD_WR_BIT];
          r_inc   <= w_data[CMD_INC_BIT];
          r_cnt   <= '0;
          r_state <= S_ADDR;
          sdata   <= 8'h00;
          overrun <= 1'b0;
        end else if (w_pending) begin
          overrun <= 1'b1;
        end else begin
          case (r_state)
            S_ADDR: begin
              bus_addr <= w_addr_shift;
              r_cnt    <= r_cnt + 1'b1;
              if (w_last) begin
                if (r_wr) begin
                  r_state <= S_WDATA;
                end else begin
                  r_state <= S_RDATA;
                  bus_re  <= 1'b1;
                end
              end
            end
            S_WDATA: begin
              bus_wdata <= w_data;
              bus_we    <= 1'b1;
            end
            S_RDATA: begin
              if (r_inc)
                bus_addr <= w_addr_inc;
              bus_re <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_bridge.sv
`default_nettype none
// ============================================================================
// tb_spi_cmd_bridge : directed self-checking bench for spi_cmd_bridge
// Revision: 1.0
// ============================================================================
module tb_spi_cmd_bridge;

  logic        clk;
  logic        rst;
  logic [7:0]  mdata;
  logic        data_valid_read;
  logic        data_firstbyte;
  logic [7:0]  sdata;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_we;
  logic        bus_re;
  logic [7:0]  bus_rdata;
  logic        bus_ack;
  logic        overrun;

  int          n_tests;
  int          n_fail;
  logic        ack_en;
  int          lat;
  logic [15:0] wl_addr [0:15];
  logic [7:0]  wl_data [0:15];
  int          wl_cnt;
  int          rd_cnt;
  logic [7:0]  rd_mem [0:255];

  spi_cmd_bridge #(.ADDR_BYTES(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .mdata           (mdata),
    .data_valid_read (data_valid_read),
    .data_firstbyte  (data_firstbyte),
    .sdata           (sdata),
    .bus_addr        (bus_addr),
    .bus_wdata       (bus_wdata),
    .bus_we          (bus_we),
    .bus_re          (bus_re),
    .bus_rdata       (bus_rdata),
    .bus_ack         (bus_ack),
    .overrun         (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic first);
    mdata           = d;
    data_firstbyte  = first;
    data_valid_read = ~data_valid_read;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bus slave: acks after a short latency, logs writes, serves reads from rd_mem.
  initial begin
    bus_ack   = 1'b0;
    bus_rdata = 8'h00;
    lat       = 0;
    wl_cnt    = 0;
    rd_cnt    = 0;
    forever begin
      @(negedge clk);
      if (bus_ack) begin
        bus_ack = 1'b0;
      end else if (ack_en && (bus_we || bus_re)) begin
        if (lat == 2) begin
          lat     = 0;
          bus_ack = 1'b1;
          if (bus_we) begin
            if (wl_cnt < 16) begin
              wl_addr[wl_cnt] = bus_addr;
              wl_data[wl_cnt] = bus_wdata;
            end
            wl_cnt++;
          end else begin
            bus_rdata = rd_mem[bus_addr[7:0]];
            rd_cnt++;
          end
        end else begin
          lat++;
        end
      end else begin
        lat = 0;
      end
    end
  end

  initial begin
    n_tests         = 0;
    n_fail          = 0;
    ack_en          = 1'b0;
    rst             = 1'b0;
    mdata           = 8'h00;
    data_valid_read = 1'b0;
    data_firstbyte  = 1'b0;
    for (int i = 0; i < 256; i++) rd_mem[i] = 8'h00;
    rd_mem[8'h10] = 8'h5A;
    rd_mem[8'h11] = 8'h5B;
    rd_mem[8'h12] = 8'h5C;
    rd_mem[8'h40] = 8'h9E;

    wait_clks(3);
    check_val("rst sdata", {24'd0, sdata}, 32'h00);
    check_val("rst we/re/ovr", {29'd0, bus_we, bus_re, overrun}, 32'h0);
    rst = 1'b1;
    wait_clks(2);

    // Reset in the middle of a pending write
    send_byte(8'hC0, 1'b1);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'hAA, 1'b0);
    check_val("pre-rst we", {31'd0, bus_we}, 32'h1);
    check_val("pre-rst wdata", {24'd0, bus_wdata}, 32'hAA);
    rst             = 1'b0;
    data_valid_read = 1'b0;
    wait_clks(2);
    check_val("midrst addr", {16'd0, bus_addr}, 32'h0);
    check_val("midrst wdata", {24'd0, bus_wdata}, 32'h0);
    check_val("midrst we/re/ovr/sd", {21'd0, bus_we, bus_re, overrun, sdata}, 32'h0);
    rst = 1'b1;
    wait_clks(2);
    send_byte(8'h55, 1'b0);
    check_val("no-sync we", {31'd0, bus_we}, 32'h0);
    check_val("no-sync wcnt", wl_cnt, 0);

    // Auto-increment writes
    ack_en = 1'b1;
    wl_cnt = 0;
    send_byte(8'hC0, 1'b1);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    check_val("winc cnt", wl_cnt, 2);
    check_val("winc w0", {8'd0, wl_addr[0], wl_data[0]}, 32'h1234AA);
    check_val("winc w1", {8'd0, wl_addr[1], wl_data[1]}, 32'h1235BB);
    check_val("winc sdata", {24'd0, sdata}, 32'h00);

    // Fixed-address writes
    wl_cnt = 0;
    send_byte(8'h80, 1'b1);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    check_val("wfix cnt", wl_cnt, 2);
    check_val("wfix w0", {8'd0, wl_addr[0], wl_data[0]}, 32'h1234AA);
    check_val("wfix w1", {8'd0, wl_addr[1], wl_data[1]}, 32'h1234BB);

    // Auto-increment reads
    rd_cnt = 0;
    send_byte(8'h40, 1'b1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h10, 1'b0);
    check_val("rd sdata0", {24'd0, sdata}, 32'h5A);
    check_val("rd re idle", {31'd0, bus_re}, 32'h0);
    send_byte(8'hEE, 1'b0);
    check_val("rd sdata1", {24'd0, sdata}, 32'h5B);
    send_byte(8'hEE, 1'b0);
    check_val("rd sdata2", {24'd0, sdata}, 32'h5C);
    check_val("rd addr", {16'd0, bus_addr}, 32'h0012);
    check_val("rd cnt", rd_cnt, 3);

    // Address wrap
    wl_cnt = 0;
    send_byte(8'hC0, 1'b1);
    check_val("cmd clr sdata", {24'd0, sdata}, 32'h00);
    send_byte(8'hFF, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    check_val("wrap cnt", wl_cnt, 2);
    check_val("wrap w0", {8'd0, wl_addr[0], wl_data[0]}, 32'hFFFF11);
    check_val("wrap w1", {8'd0, wl_addr[1], wl_data[1]}, 32'h000022);

    // Overrun with ack held off
    ack_en = 1'b0;
    wl_cnt = 0;
    send_byte(8'hC0, 1'b1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h20, 1'b0);
    send_byte(8'h33, 1'b0);
    check_val("ovr before", {31'd0, overrun}, 32'h0);
    send_byte(8'h44, 1'b0);
    check_val("ovr set", {31'd0, overrun}, 32'h1);
    check_val("ovr wdata kept", {24'd0, bus_wdata}, 32'h33);
    ack_en = 1'b1;
    wait_clks(10);
    check_val("ovr wcnt", wl_cnt, 1);
    check_val("ovr w0", {8'd0, wl_addr[0], wl_data[0]}, 32'h002033);
    check_val("ovr sticky", {31'd0, overrun}, 32'h1);
    send_byte(8'h40, 1'b1);
    check_val("ovr cleared", {31'd0, overrun}, 32'h0);

    // Abort during data phase with a write still pending
    ack_en = 1'b0;
    wl_cnt = 0;
    send_byte(8'hC0, 1'b1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h30, 1'b0);
    send_byte(8'h77, 1'b0);
    send_byte(8'h00, 1'b1);
    check_val("abort we held", {31'd0, bus_we}, 32'h1);
    check_val("abort ovr", {31'd0, overrun}, 32'h0);
    ack_en = 1'b1;
    wait_clks(10);
    check_val("abort wcnt", wl_cnt, 1);
    check_val("abort w0", {8'd0, wl_addr[0], wl_data[0]}, 32'h003077);
    rd_cnt = 0;
    send_byte(8'h00, 1'b0);
    send_byte(8'h40, 1'b0);
    check_val("abort rd sdata", {24'd0, sdata}, 32'h9E);
    send_byte(8'hEE, 1'b0);
    check_val("abort rd addr", {16'd0, bus_addr}, 32'h0040);
    check_val("abort rd cnt", rd_cnt, 2);
    check_val("abort wcnt end", wl_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
